// File: rtl/fpu_mult_issuer.sv
//------------------------------------------------------------------------------
// fpu_mult_issuer
//
// Sequences one single-precision multiply at a time through an external
// multiplier. It accepts an operand pair and classifies each operand as
// inf/nan/zero for the multiplier. It then pulses tick_exec and waits for
// instr_finished. Finally it holds the captured product until the
// downstream side takes it.
//
// Optional feature macro: FPU_ISSUE_TIMEOUT_EN
//   When this macro is defined, a watchdog counts WAIT cycles. After
//   TIMEOUT_CYCLES cycles with no instr_finished, the block answers with a
//   quiet NaN (0x7FC00000) and flags 4'b1100 (timeout | invalid).
//   When the macro is undefined, no counter exists and WAIT lasts until
//   instr_finished.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req_valid/req_ready, op_a/op_b  upstream operand handshake
//   tick_exec                       one-cycle multiplier start pulse
//   reg1, reg2                      operands presented to the multiplier
//   reg_params                      {is_inf[1:0], is_nan[1:0], is_zero[1:0]},
//                                   where bit0 is reg1 and bit1 is reg2
//   instr_finished, reg_lo          multiplier done strobe and product
//   mult_overflow/underflow/invalid multiplier status flags
//   rsp_valid/rsp_ready, rsp_data   downstream result handshake
//   rsp_flags                       {timeout, invalid, underflow, overflow}
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a new operand pair
// LAUNCH | operands registered; tick_exec high for this one cycle
// WAIT   | multiplier running; waiting for instr_finished (or watchdog)
// RESP   | result valid; holding until rsp_ready
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module fpu_mult_issuer #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BIT_WIDTH-1:0] op_a,
  input  logic [BIT_WIDTH-1:0] op_b,
  output logic                 tick_exec,
  output logic [BIT_WIDTH-1:0] reg1,
  output logic [BIT_WIDTH-1:0] reg2,
  output logic [5:0]           reg_params,
  input  logic                 instr_finished,
  input  logic [BIT_WIDTH-1:0] reg_lo,
  input  logic                 mult_overflow,
  input  logic                 mult_underflow,
  input  logic                 mult_invalid,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BIT_WIDTH-1:0] rsp_data,
  output logic [3:0]           rsp_flags
);

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0] cls_a, cls_b;
  logic       wait_done;

  // Returns {is_inf, is_nan, is_zero}. The sign bit is not used. A zero
  // exponent counts as zero whatever the fraction is, so denormals are
  // treated as zero.
  function automatic logic [2:0] classify(input logic [EXP_W+FRAC_W-1:0] v);
    logic exp_ones, exp_zero, frac_zero;
    exp_ones  = &v[FRAC_W +: EXP_W];
    exp_zero  = ~|v[FRAC_W +: EXP_W];
    frac_zero = ~|v[FRAC_W-1:0];
    classify  = {exp_ones & frac_zero, exp_ones & ~frac_zero, exp_zero};
  endfunction

  assign cls_a = classify(op_a[EXP_W+FRAC_W-1:0]);
  assign cls_b = classify(op_b[EXP_W+FRAC_W-1:0]);

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BIT_WIDTH-1:0] QNAN = BIT_WIDTH'(32'h7FC0_0000);

  logic [CNT_W-1:0] wdog_cnt;
  logic             timeout_hit;

  // The counter is loaded during LAUNCH, so WAIT lasts exactly
  // TIMEOUT_CYCLES cycles. The count reaches zero in the last of those
  // cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      wdog_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (state == S_WAIT) begin
      if (wdog_cnt != '0) wdog_cnt <= wdog_cnt - 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end

  // A real completion takes priority over a watchdog expiry in the same cycle.
  assign timeout_hit = (state == S_WAIT) && (wdog_cnt == '0) && !instr_finished;
  assign wait_done   = instr_finished | timeout_hit;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wait_done = instr_finished;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (req_valid) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (wait_done) state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = 1'b0;
    tick_exec = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE:   req_ready = 1'b1;
      S_LAUNCH: tick_exec = 1'b1;
      S_WAIT:   ;
      S_RESP:   rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Operand registers change only on accept, so they stay stable through
  // LAUNCH and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg1       <= '0;
      reg2       <= '0;
      reg_params <= '0;
    end else if (state == S_IDLE && req_valid) begin
      reg1       <= op_a;
      reg2       <= op_b;
      reg_params <= {cls_b[2], cls_a[2], cls_b[1], cls_a[1], cls_b[0], cls_a[0]};
    end
  end

  // Result capture happens only in WAIT. An instr_finished in any other
  // state has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else if (state == S_WAIT) begin
      if (instr_finished) begin
        rsp_data  <= reg_lo;
        rsp_flags <= {1'b0, mult_invalid, mult_underflow, mult_overflow};
      end
`ifdef FPU_ISSUE_TIMEOUT_EN
      else if (timeout_hit) begin
        rsp_data  <= QNAN;
        rsp_flags <= 4'b1100;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fpu_mult_issuer.sv
`timescale 1ns/1ps

module tb_fpu_mult_issuer;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] op_a, op_b;
  logic         tick_exec;
  logic [W-1:0] reg1, reg2;
  logic [5:0]   reg_params;
  logic         instr_finished;
  logic [W-1:0] reg_lo;
  logic         mult_overflow, mult_underflow, mult_invalid;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;

  fpu_mult_issuer #(.BIT_WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .op_a           (op_a),
    .op_b           (op_b),
    .tick_exec      (tick_exec),
    .reg1           (reg1),
    .reg2           (reg2),
    .reg_params     (reg_params),
    .instr_finished (instr_finished),
    .reg_lo         (reg_lo),
    .mult_overflow  (mult_overflow),
    .mult_underflow (mult_underflow),
    .mult_invalid   (mult_invalid),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_flags      (rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard entries are {flags[3:0], data[31:0]}
  logic [35:0] sb_q[$];
  logic [35:0] sb_exp;

  // Multiplier model: it starts on a tick_exec pulse and raises
  // instr_finished for one cycle after mdl_lat WAIT cycles.
  int           mdl_lat  = 5;
  logic [W-1:0] mdl_res  = '0;
  logic [2:0]   mdl_flg  = '0;   // {invalid, underflow, overflow}
  logic         mdl_busy = 1'b0;
  int           tick_cnt = 0;

  initial begin
    instr_finished = 1'b0;
    reg_lo         = 32'hDEAD_BEEF;
    {mult_invalid, mult_underflow, mult_overflow} = 3'b111;
    forever begin
      @(negedge clk);
      if (tick_exec === 1'b1) begin
        mdl_busy = 1'b1;
        @(posedge clk);
        repeat (mdl_lat - 1) @(posedge clk);
        #1;
        instr_finished = 1'b1;
        reg_lo         = mdl_res;
        {mult_invalid, mult_underflow, mult_overflow} = mdl_flg;
        @(posedge clk);
        #1;
        instr_finished = 1'b0;
        reg_lo         = 32'hDEAD_BEEF;
        {mult_invalid, mult_underflow, mult_overflow} = 3'b111;
        mdl_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) if (tick_exec === 1'b1) tick_cnt++;

  // Result collector
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("rsp_data", rsp_data, sb_exp[31:0]);
        check("rsp_flags", {28'd0, rsp_flags}, {28'd0, sb_exp[35:32]});
      end
    end
  end

  function automatic logic [5:0] exp_params(input logic [W-1:0] a, input logic [W-1:0] b);
    logic ia, na, za, ib, nb, zb;
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    za = (a[30:23] == 8'h00);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    zb = (b[30:23] == 8'h00);
    return {ib, ia, nb, na, zb, za};
  endfunction

  task automatic wait_model_idle();
    int g;
    g = 0;
    while (mdl_busy && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (mdl_busy) check("model_idle_timeout", 32'd1, 32'd0);
    #1;
  endtask

  // Drives one request and returns #1 after the accepting edge (FSM in LAUNCH).
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] prm);
    int g;
    @(posedge clk);
    #1;
    op_a      = a;
    op_b      = b;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!req_ready) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op_a      = $urandom;
    op_b      = $urandom;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    check("reg1", reg1, a);
    check("reg2", reg2, b);
    check("reg_params", {26'd0, reg_params}, {26'd0, prm});
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] prm,
                         input logic [W-1:0] res, input logic [2:0] flg, input int lat,
                         input logic [W-1:0] e_data, input logic [3:0] e_flags,
                         input int e_cycles, input int hold);
    int n, t0;
    logic unstable;
    wait_model_idle();
    mdl_res   = res;
    mdl_flg   = flg;
    mdl_lat   = lat;
    rsp_ready = (hold == 0);
    sb_q.push_back({e_flags, e_data});
    t0 = tick_cnt;
    issue(a, b, prm);
    n = 0;
    unstable = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!rsp_valid && (reg1 !== a || reg2 !== b || reg_params !== prm)) unstable = 1'b1;
    end while (!rsp_valid && n < 200);
    check("rsp_latency", n, e_cycles);
    check("operands_stable", {31'd0, unstable}, 32'd0);
    if (hold > 0) begin
      unstable = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== e_data || req_ready !== 1'b0) unstable = 1'b1;
      end
      check("hold_stable", {31'd0, unstable}, 32'd0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("req_ready_after", {31'd0, req_ready}, 32'd1);
    check("tick_pulses", tick_cnt - t0, 32'd1);
  endtask

  logic [W-1:0] pool [8];
  initial begin
    pool[0] = 32'h3F80_0000; pool[1] = 32'h7F80_0000; pool[2] = 32'hFF80_0000;
    pool[3] = 32'h7FC0_0001; pool[4] = 32'h0000_0000; pool[5] = 32'h8000_0001;
    pool[6] = 32'hC120_0000; pool[7] = 32'h007F_FFFF;
  end

  initial begin
    int saw;
    logic [W-1:0] a, b, r;
    logic [2:0] f;
    int l;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_tick", {31'd0, tick_exec}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_reg1", reg1, 32'd0);
    check("rst_params", {26'd0, reg_params}, 32'd0);
    check("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    rst_n = 1'b1;

    // 1.0 * 2.0
    run_txn(32'h3F80_0000, 32'h4000_0000, 6'b000000, 32'h4000_0000, 3'b000, 5,
            32'h4000_0000, 4'b0000, 7, 0);
    // inf * 0 -> invalid
    run_txn(32'h7F80_0000, 32'h0000_0000, 6'b010010, 32'hFF80_0001, 3'b100, 3,
            32'hFF80_0001, 4'b0100, 5, 0);
    // Backpressure for 4 cycles
    run_txn(32'h4040_0000, 32'h7FC0_0000, 6'b001000, 32'h1234_5678, 3'b011, 2,
            32'h1234_5678, 4'b0011, 4, 4);
    // Minimum multiplier latency
    run_txn(32'h0000_0001, 32'hFF80_0000, 6'b100001, 32'hCAFE_F00D, 3'b001, 1,
            32'hCAFE_F00D, 4'b0001, 3, 0);

    // Long multiplier: with the watchdog enabled, it times out after 16 WAIT cycles
`ifdef FPU_ISSUE_TIMEOUT_EN
    run_txn(32'h3F80_0000, 32'h3F80_0000, 6'b000000, 32'h3F80_0000, 3'b000, 40,
            32'h7FC0_0000, 4'b1100, 18, 0);
`else
    run_txn(32'h3F80_0000, 32'h3F80_0000, 6'b000000, 32'h3F80_0000, 3'b000, 40,
            32'h3F80_0000, 4'b0000, 42, 0);
`endif

    // Reset two cycles into WAIT; the late finish must be ignored
    wait_model_idle();
    mdl_lat = 10;
    mdl_res = 32'h5555_AAAA;
    mdl_flg = 3'b010;
    issue(32'h4100_0000, 32'h4200_0000, 6'b000000);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("async_rst_reg1", reg1, 32'd0);
    check("async_rst_rsp_data", rsp_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1;
    end
    check("rst_no_rsp", saw, 32'd0);
    check("rst_idle_ready", {31'd0, req_ready}, 32'd1);

    // Randomised operand classes
    for (int k = 0; k < 6; k++) begin
      a = pool[$urandom_range(0, 7)];
      b = pool[$urandom_range(0, 7)];
      r = $urandom;
      f = 3'($urandom_range(0, 7));
      l = $urandom_range(1, 6);
      run_txn(a, b, exp_params(a, b), r, f, l, r, {1'b0, f}, l + 2, (k == 2) ? 2 : 0);
    end

    wait_model_idle();
    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fpu_mult_issuer.md
FPU_MULT_ISSUER -- requirements
Module: fpu_mult_issuer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, operand/result width (IEEE-754 single layout).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, WAIT-state watchdog limit (used only with FPU_ISSUE_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  upstream operand pair valid.
REQ-006 SHALL have port req_ready  out  1  issuer can accept a request.
REQ-007 SHALL have port op_a, op_b  in  BIT_WIDTH  upstream operands.
REQ-008 SHALL have port tick_exec  out  1  multiplier start pulse.
REQ-009 SHALL have port reg1, reg2  out  BIT_WIDTH  operands to multiplier (op_a, op_b).
REQ-010 SHALL have port reg_params  out  6  {is_inf[1:0], is_nan[1:0], is_zero[1:0]}; bit0 = reg1, bit1 = reg2.
REQ-011 SHALL have port instr_finished  in  1  multiplier done.
REQ-012 SHALL have port reg_lo  in  BIT_WIDTH  multiplier result.
REQ-013 SHALL have port mult_overflow, mult_underflow, mult_invalid  in  1 each  multiplier status flags.
REQ-014 SHALL have port rsp_valid  out  1  result valid downstream.
REQ-015 SHALL have port rsp_ready  in  1  downstream accepts result.
REQ-016 SHALL have port rsp_data  out  BIT_WIDTH  captured product.
REQ-017 SHALL have port rsp_flags  out  4  {timeout, invalid, underflow, overflow}.

Function
REQ-018 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake is req_valid & req_ready on a rising edge, moving to LAUNCH.
REQ-020 On accept SHALL register reg1=op_a, reg2=op_b and reg_params from op_a/op_b.
REQ-021 Classification: exp all-ones & frac zero -> is_inf; exp all-ones & frac nonzero -> is_nan; exp zero (any frac, denormals flushed) -> is_zero; sign ignored.
REQ-022 reg1, reg2, reg_params SHALL remain stable from accept until leaving WAIT.
REQ-023 tick_exec SHALL be 1 for exactly the single cycle the FSM is in LAUNCH; LAUNCH -> WAIT unconditionally.
REQ-024 In WAIT, instr_finished=1 at a rising edge SHALL capture reg_lo into rsp_data and mult flags into rsp_flags[2:0], clear rsp_flags[3], move to RESP.
REQ-025 instr_finished SHALL be ignored in IDLE, LAUNCH and RESP.
REQ-026 In RESP rsp_valid=1 and rsp_data/rsp_flags SHALL hold until rsp_valid & rsp_ready, then return to IDLE (next accept earliest the following cycle).
REQ-027 Minimum accept-to-rsp_valid latency SHALL be 3 cycles plus multiplier latency; no request overlap.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, req_ready=1, tick_exec=0, rsp_valid=0, reg1=reg2=0, reg_params=0, rsp_data=0, rsp_flags=0, watchdog=0.
REQ-029 Reset in any state, including mid-WAIT, SHALL discard the in-flight operation; a subsequent instr_finished in IDLE is ignored.

Configuration
REQ-030 Macro FPU_ISSUE_TIMEOUT_EN defined: watchdog counts WAIT cycles; at TIMEOUT_CYCLES without instr_finished, SHALL enter RESP with rsp_data=32'h7FC00000, rsp_flags=4'b1100.
REQ-031 Macro FPU_ISSUE_TIMEOUT_EN undefined: no counter synthesized; WAIT persists until instr_finished; rsp_flags[3] constant 0.

Verification
REQ-032 op_a=0x3F800000, op_b=0x40000000, model returns 0x40000000 after 5 cycles -> reg_params=0, one tick_exec pulse, rsp_data=0x40000000, rsp_flags=0.
REQ-033 op_a=0x7F800000, op_b=0x00000000 -> reg_params=6'b010010; model returns 0xFF800001, mult_invalid=1 -> rsp_flags=4'b0100.
REQ-034 Result ready with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout; completes on rsp_ready=1.
REQ-035 rst_n pulsed low 2 cycles into WAIT, late instr_finished after release -> rsp_valid never asserts, req_ready=1.
REQ-036 FPU_ISSUE_TIMEOUT_EN defined, model never finishes -> rsp_valid after 16 WAIT cycles, rsp_data=0x7FC00000, rsp_flags=4'b1100.
